// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequences one AES block through NR rounds of an external round datapath
//
// Ports:
//   clk, rst      rising-edge clock, asynchronous active-high reset
//   in_*          block input handshake (in_valid_i / in_ready_o), block data, direction inv_i
//   rk_*          round-key request: rk_req_o / rk_idx_o out, rk_valid_i / rk_data_i in
//   dp_*          to/from round datapath: state, key, direction, final-round flag, one-round result
//   out_*         result handshake (out_valid_o / out_ready_i) and result block
//   busy_o        high whenever the controller is not idle
//
// Macro AES_ROUND_CTRL_INV_EN: when defined, decryption (reverse key order, latched inv) is built;
// otherwise inv_i is ignored and every block is encrypted.
module aes_round_ctrl #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [127:0] in_data_i,
   input  logic         inv_i,
   output logic         rk_req_o,
   output logic [3:0]   rk_idx_o,
   input  logic         rk_valid_i,
   input  logic [127:0] rk_data_i,
   output logic [127:0] dp_state_o,
   output logic [127:0] dp_key_o,
   output logic         dp_inv_o,
   output logic         dp_final_o,
   input  logic [127:0] dp_result_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [127:0] out_data_o,
   output logic         busy_o
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [3:0] NR4 = 4'(NR);
   state_t state, state_n;
   logic [3:0] rnd, rnd_n;
   logic [127:0] st, st_n;
   logic inv_q;
   logic run;
   assign run = state == RUN;
`ifdef AES_ROUND_CTRL_INV_EN
   logic inv_n;
   assign inv_n = (state == IDLE && in_valid_i) ? inv_i : inv_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) inv_q <= 1'b0;
      else inv_q <= inv_n;
   // decryption walks the key schedule backwards
   assign rk_idx_o = run ? (inv_q ? NR4 - rnd : rnd) : 4'd0;
`else
   logic unused_inv;
   assign unused_inv = inv_i;
   assign inv_q = 1'b0;
   assign rk_idx_o = run ? rnd : 4'd0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         rnd   <= 4'd0;
         st    <= 128'd0;
      end else begin
         state <= state_n;
         rnd   <= rnd_n;
         st    <= st_n;
      end
   always_comb begin
      state_n     = state;
      rnd_n       = rnd;
      st_n        = st;
      in_ready_o  = 1'b0;
      rk_req_o    = 1'b0;
      out_valid_o = 1'b0;
      case (state)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               st_n    = in_data_i;
               rnd_n   = 4'd0;
               state_n = RUN;
            end
         end
         RUN: begin
            rk_req_o = 1'b1;
            if (rk_valid_i) begin
               if (rnd == 4'd0) begin
                  // initial AddRoundKey happens here, the datapath only does full rounds
                  st_n  = st ^ rk_data_i;
                  rnd_n = 4'd1;
               end else begin
                  st_n = dp_result_i;
                  if (rnd == NR4) state_n = DONE;
                  else rnd_n = rnd + 4'd1;
               end
            end
         end
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   assign dp_state_o = st;
   assign dp_key_o   = rk_data_i;
   assign dp_inv_o   = inv_q;
   assign dp_final_o = run && rnd == NR4;
   assign out_data_o = st;
   assign busy_o     = state != IDLE;
endmodule
